// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline shares one port with a
// FIFO of multicycle results. An anti-starvation stall protects the FIFO head.
// Optional decode bypass-hit outputs are enabled by defining WB_BYPASS_EN.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_wd,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        stall,
    output logic [31:0] pend_mask
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_a1,
    input  logic [4:0]  byp_a2,
    output logic        byp_hit1,
    output logic        byp_hit2
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LIMIT_C = AW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd_q [DEPTH];
    logic [31:0]   fifo_wd_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] age_q, age_d;

    logic             fifo_ne_s;
    logic             push_s;
    logic             pop_s;
    logic             pipe_wr_s;
    logic [DEPTH-1:0] ent_valid_s;

    assign fifo_ne_s = (count_q != {CW{1'b0}});
    assign mc_ready  = (count_q != DEPTH_C);
    // Writes to x0 still complete the handshake but never occupy a slot.
    assign push_s    = mc_valid && mc_ready && (mc_rd != 5'd0);
    assign pipe_wr_s = pipe_we && (pipe_rd != 5'd0);
    assign stall     = fifo_ne_s && (age_q == LIMIT_C);

    // Port arbitration: pipeline first unless the FIFO head has starved.
    always_comb begin
        we3   = 1'b0;
        a3    = 5'd0;
        wd3   = 32'd0;
        pop_s = 1'b0;
        if (!reset) begin
            we3   = 1'b0;
            pop_s = 1'b0;
        end else if (!stall && pipe_wr_s) begin
            we3 = 1'b1;
            a3  = pipe_rd;
            wd3 = pipe_wd;
        end else if (fifo_ne_s) begin
            we3   = 1'b1;
            a3    = fifo_rd_q[rd_ptr_q];
            wd3   = fifo_wd_q[rd_ptr_q];
            pop_s = 1'b1;
        end else begin
            we3 = 1'b0;
        end
    end

    // Next-state for pointers, occupancy and head age.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        age_d    = age_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (!fifo_ne_s || pop_s) begin
            age_d = {AW{1'b0}};
        end else if (age_q != LIMIT_C) begin
            age_d = age_q + AW'(1);
        end else begin
            age_d = age_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            age_q    <= {AW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_q[wr_ptr_q] <= mc_rd;
            fifo_wd_q[wr_ptr_q] <= mc_wd;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        assign ent_valid_s[g] = ({1'b0, PW'(g) - rd_ptr_q} < count_q);
    end

    // Pending-write mask over occupied slots, so duplicates hold their bit.
    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_s[i]) begin
                pend_mask = pend_mask | (32'd1 << fifo_rd_q[i]);
            end else begin
                pend_mask = pend_mask;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hit1 = we3 && (a3 != 5'd0) && (a3 == byp_a1);
    assign byp_hit2 = we3 && (a3 != 5'd0) && (a3 == byp_a2);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes go into a queue that a
// negedge monitor drains; flag outputs are compared directly per cycle.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wd;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        stall;
    logic [31:0] pend_mask;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_a1;
    logic [4:0]  byp_a2;
    logic        byp_hit1;
    logic        byp_hit2;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_wd   (pipe_wd),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_rd     (mc_rd),
        .mc_wd     (mc_wd),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .stall     (stall),
        .pend_mask (pend_mask)
`ifdef WB_BYPASS_EN
        ,
        .byp_a1    (byp_a1),
        .byp_a2    (byp_a2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Write monitor: every regfile write must match the next expected one.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got a3=%0d wd3=%h, none expected at %0t", a3, wd3, $time);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({a3, wd3} !== e) begin
                    n_fail++;
                    $display("FAIL write: got a3=%0d wd3=%h expected a3=%0d wd3=%h at %0t",
                             a3, wd3, e[36:32], e[31:0], $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        pipe_we  = 1'b1;
        pipe_rd  = 5'd5;
        pipe_wd  = 32'h0000_1111;
        mc_valid = 1'b0;
        mc_rd    = 5'd0;
        mc_wd    = 32'd0;
`ifdef WB_BYPASS_EN
        byp_a1   = 5'd0;
        byp_a2   = 5'd0;
`endif
        // Reset state with a pipeline request pending.
        sample();
        chk("rst_we3", {31'd0, we3}, 32'd0);
        chk("rst_a3", {27'd0, a3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        tick();
        reset = 1'b1;
        expect_wr(5'd5, 32'h0000_1111);
        sample();
        chk("rel_we3", {31'd0, we3}, 32'd1);
        chk("rel_a3", {27'd0, a3}, 32'd5);
        tick();

        // Single multicycle result with the pipeline idle.
        pipe_we = 1'b0;
        mc_valid = 1'b1; mc_rd = 5'd7; mc_wd = 32'hDEAD_BEEF;
        sample();
        chk("mc7_ready", {31'd0, mc_ready}, 32'd1);
        chk("mc7_pend_before", pend_mask, 32'd0);
        tick();
        mc_valid = 1'b0;
        expect_wr(5'd7, 32'hDEAD_BEEF);
        sample();
        chk("mc7_we3", {31'd0, we3}, 32'd1);
        chk("mc7_pend", pend_mask, 32'h0000_0080);
        tick();
        sample();
        chk("mc7_pend_after", pend_mask, 32'd0);

        // Result for x0 is accepted and dropped.
        tick();
        mc_valid = 1'b1; mc_rd = 5'd0; mc_wd = 32'h1234_5678;
        sample();
        chk("x0_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;
        sample();
        chk("x0_we3", {31'd0, we3}, 32'd0);
        chk("x0_pend", pend_mask, 32'd0);
        chk("x0_ready_after", {31'd0, mc_ready}, 32'd1);

        // Pipeline write to x0 is ignored.
        tick();
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hFFFF_0000;
        sample();
        chk("pipe_x0_we3", {31'd0, we3}, 32'd0);
        tick();

        // Two queued entries for x9 while the pipeline owns the port.
        pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h4000_0000;
        mc_valid = 1'b1; mc_rd = 5'd9; mc_wd = 32'hA1A1_A1A1;
        expect_wr(5'd4, 32'h4000_0000);
        sample();
        chk("dup_pend0", pend_mask, 32'd0);
        tick();
        pipe_wd = 32'h4000_0001; mc_wd = 32'hA2A2_A2A2;
        expect_wr(5'd4, 32'h4000_0001);
        sample();
        chk("dup_pend1", pend_mask, 32'h0000_0200);
        tick();
        pipe_we = 1'b0; mc_valid = 1'b0;
        expect_wr(5'd9, 32'hA1A1_A1A1);
        sample();
        chk("dup_full_ready", {31'd0, mc_ready}, 32'd0);
        chk("dup_pend2", pend_mask, 32'h0000_0200);
        tick();
        expect_wr(5'd9, 32'hA2A2_A2A2);
        sample();
        chk("dup_pend_after_first", pend_mask, 32'h0000_0200);
        tick();
        sample();
        chk("dup_pend_clear", pend_mask, 32'd0);
        tick();

        // Starvation: pipeline writes x3 every cycle until the stall forces the head.
        for (int c = 0; c < 9; c++) begin
            pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h3000_0000 + 32'(c);
            mc_valid = (c < 2);
            mc_rd = (c == 0) ? 5'd10 : 5'd11;
            mc_wd = (c == 0) ? 32'hB1B1_B1B1 : 32'hB2B2_B2B2;
            expect_wr(5'd3, 32'h3000_0000 + 32'(c));
            sample();
            chk("starve_stall_low", {31'd0, stall}, 32'd0);
            chk("starve_ready", {31'd0, mc_ready}, (c < 2) ? 32'd1 : 32'd0);
            chk("starve_pend", pend_mask,
                (c == 0) ? 32'd0 : ((c == 1) ? 32'h0000_0400 : 32'h0000_0C00));
            tick();
        end
        mc_valid = 1'b0;
        pipe_wd = 32'h3000_0009;
        expect_wr(5'd10, 32'hB1B1_B1B1);
        sample();
        chk("starve_stall_high", {31'd0, stall}, 32'd1);
        tick();
        expect_wr(5'd3, 32'h3000_0009);
        sample();
        chk("starve_stall_drop", {31'd0, stall}, 32'd0);
        chk("starve_pend_second", pend_mask, 32'h0000_0800);
        tick();
        pipe_we = 1'b0;
        expect_wr(5'd11, 32'hB2B2_B2B2);
        sample();
        chk("starve_ready_again", {31'd0, mc_ready}, 32'd1);
        tick();
        sample();
        chk("starve_pend_empty", pend_mask, 32'd0);
        tick();

        // Reset mid-operation discards queued entries.
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'hE000_0000;
        mc_valid = 1'b1; mc_rd = 5'd20; mc_wd = 32'hC0C0_C0C0;
        expect_wr(5'd3, 32'hE000_0000);
        tick();
        pipe_wd = 32'hE000_0001; mc_rd = 5'd21;
        expect_wr(5'd3, 32'hE000_0001);
        tick();
        reset = 1'b0; pipe_we = 1'b0; mc_valid = 1'b0;
        sample();
        chk("midrst_pend", pend_mask, 32'd0);
        chk("midrst_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        reset = 1'b1;
        sample();
        chk("midrst_no_write", {31'd0, we3}, 32'd0);
        chk("midrst_pend_after", pend_mask, 32'd0);
        tick();

`ifdef WB_BYPASS_EN
        pipe_we = 1'b1; pipe_rd = 5'd12; pipe_wd = 32'h0C0C_0C0C;
        byp_a1 = 5'd12; byp_a2 = 5'd0;
        expect_wr(5'd12, 32'h0C0C_0C0C);
        sample();
        chk("byp_hit1", {31'd0, byp_hit1}, 32'd1);
        chk("byp_hit2", {31'd0, byp_hit2}, 32'd0);
        tick();
        pipe_rd = 5'd0; byp_a1 = 5'd0;
        sample();
        chk("byp_x0_hit1", {31'd0, byp_hit1}, 32'd0);
        tick();
        pipe_we = 1'b0;
`endif

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, meaning: multicycle-result FIFO entries (power of two, ≥2).
REQ-002 Parameter STARVE_LIMIT, default 8, meaning: consecutive cycles the FIFO head may lose arbitration before a pipeline stall is forced.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pipe_we  in  1  in-order pipeline writeback request.
REQ-006 pipe_rd  in  5  pipeline destination register.
REQ-007 pipe_wd  in  32  pipeline write data.
REQ-008 mc_valid  in  1  multicycle unit (load/divide) result valid.
REQ-009 mc_ready  out  1  arbiter can accept mc result.
REQ-010 mc_rd  in  5  multicycle destination register.
REQ-011 mc_wd  in  32  multicycle result data.
REQ-012 we3  out  1  register file write enable.
REQ-013 a3  out  5  register file write address.
REQ-014 wd3  out  32  register file write data.
REQ-015 stall  out  1  request to freeze the pipeline writeback stage.
REQ-016 pend_mask  out  32  bit n set: a write to xn is queued in the FIFO.

Function
REQ-017 mc handshake completes on a cycle with mc_valid && mc_ready; mc_ready = (count != DEPTH), derived from registered count only, never from same-cycle pop.
REQ-018 Accepted mc result with mc_rd != 0 is pushed to the FIFO tail; mc_rd == 0 completes the handshake but is discarded.
REQ-019 Pipeline request is a write only when pipe_we && pipe_rd != 0; otherwise it is ignored.
REQ-020 Write port is combinational, zero latency: stall low and valid pipe request -> we3=1, a3=pipe_rd, wd3=pipe_wd.
REQ-021 Else, FIFO non-empty -> we3=1, a3/wd3 = head entry, head popped at the clock edge.
REQ-022 Else we3=0, a3=0, wd3=0.
REQ-023 Simultaneous push and pop in one cycle: both occur, count unchanged; push into an empty FIFO is not written to the regfile the same cycle.
REQ-024 Age counter: increments each cycle the FIFO is non-empty and head not popped; clears on pop or when empty; saturates at STARVE_LIMIT.
REQ-025 stall = (age == STARVE_LIMIT) && FIFO non-empty; while stall is high the FIFO head wins the port and the pipeline holds its request unchanged (pipe request not written that cycle).
REQ-026 pend_mask is combinational OR over valid FIFO entries of one-hot(rd); duplicate rd bit clears only when the last matching entry pops.
REQ-027 FIFO pointers wrap modulo DEPTH; count width holds 0..DEPTH.

Reset
REQ-028 reset low clears count, pointers and age immediately: mc_ready=1, we3=0, a3=0, wd3=0, stall=0, pend_mask=0.
REQ-029 Reset asserted mid-operation discards all queued entries; in-flight handshake that cycle is lost.
REQ-030 FIFO data storage is not reset.

Configuration
REQ-031 Macro WB_BYPASS_EN defined: adds inputs byp_a1/byp_a2 (5) and outputs byp_hit1/byp_hit2 (1), byp_hitN = we3 && a3 != 0 && a3 == byp_aN, combinational, so the decode stage selects wd3 over the stale regfile read.
REQ-032 Macro undefined: those ports do not exist; all other behaviour identical.

Verification
REQ-033 Reset low with pipe_we=1, pipe_rd=5 -> we3=0, mc_ready=1, pend_mask=0; release -> we3=1, a3=5 same cycle.
REQ-034 mc_rd=7, mc_wd=0xDEADBEEF accepted, pipe idle -> next cycle we3=1, a3=7, wd3=0xDEADBEEF, pend_mask[7] high for exactly that cycle.
REQ-035 Two mc pushes while pipe writes x3 every cycle -> mc_ready=0 after second push; stall rises after 8 losing cycles; head writes, then second entry, stall drops.
REQ-036 mc_rd=0 accepted -> FIFO count unchanged, no regfile write, pend_mask=0.
REQ-037 Two queued entries both rd=9 -> pend_mask[9] stays high after first pop, clears after second.
REQ-038 WB_BYPASS_EN defined, pipe write x12, byp_a1=12, byp_a2=0 -> byp_hit1=1, byp_hit2=0; write to x0 with byp_a1=0 -> byp_hit1=0.
